// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame sequencer: FSM state encoding,
// default array geometry and timing constants.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONV      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_REQ       = 3'd3,
    ST_WAIT_WORD = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int ADC_CHIP_NO    = 4;
  localparam int ADC_CH_NO      = 4;
  localparam int DEF_CONVST_CYC = 3;
  localparam int DEF_BUSY_TO    = 255;

endpackage

// File: rtl/adc_idx_counter.sv
// Nested chip/channel counter: channel is the inner index, chip the outer.
// Both wrap at their configured maxima rather than at the 2-bit overflow.
module adc_idx_counter
  import adc_pkg::*;
#(
  parameter int N_CHIPS = ADC_CHIP_NO,
  parameter int N_CH    = ADC_CH_NO
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [1:0] chip_idx,
  output logic [1:0] ch_idx,
  output logic       last
);

  localparam logic [1:0] CHIP_MAX = 2'(N_CHIPS - 1);
  localparam logic [1:0] CH_MAX   = 2'(N_CH - 1);

  logic [1:0] chip_q;
  logic [1:0] ch_q;

  always_ff @(posedge clkin) begin
    if (rst || clr) begin
      chip_q <= 2'd0;
      ch_q   <= 2'd0;
    end else if (adv) begin
      if (ch_q == CH_MAX) begin
        ch_q   <= 2'd0;
        chip_q <= (chip_q == CHIP_MAX) ? 2'd0 : chip_q + 2'd1;
      end else begin
        ch_q <= ch_q + 2'd1;
      end
    end
  end

  assign chip_idx = chip_q;
  assign ch_idx   = ch_q;
  assign last     = (chip_q == CHIP_MAX) && (ch_q == CH_MAX);

endmodule

// File: rtl/adc_frame_sequencer.sv
// Frame scheduler for the parallel ADC front end: convert-start pulse, BUSY
// wait with timeout, then one read request per (chip, channel) word.
module adc_frame_sequencer
  import adc_pkg::*;
#(
  parameter int N_CHIPS    = ADC_CHIP_NO,
  parameter int N_CH       = ADC_CH_NO,
  parameter int CONVST_CYC = DEF_CONVST_CYC,
  parameter int BUSY_TO    = DEF_BUSY_TO
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               start,
  input  logic [N_CHIPS-1:0] busy,
  input  logic               word_done,
  output logic               convst_bar,
  output logic               rd_req,
  output logic [1:0]         chip_idx,
  output logic [1:0]         ch_idx,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               err_overrun,
  output logic               err_timeout
);

  localparam logic [7:0] CONV_LAST = 8'(CONVST_CYC - 1);
  localparam logic [7:0] TO_LAST   = 8'(BUSY_TO - 1);

  state_e     state_q;
  logic [7:0] conv_cnt_q;
  logic [7:0] to_cnt_q;
  logic       convst_bar_q;
  logic       rd_req_q;
  logic       frame_busy_q;
  logic       frame_done_q;
  logic       err_overrun_q;
  logic       err_timeout_q;

  logic       idx_clr;
  logic       idx_adv;
  logic       idx_last;
  logic       busy_clear;

  // BUSY may not have risen yet in the first two WAIT_BUSY cycles.
  assign busy_clear = (busy == '0) && (to_cnt_q >= 8'd2);
  assign idx_adv    = (state_q == ST_WAIT_WORD) && word_done;
  assign idx_clr    = (state_q == ST_IDLE);

  adc_idx_counter #(
    .N_CHIPS (N_CHIPS),
    .N_CH    (N_CH)
  ) u_idx (
    .clkin    (clkin),
    .rst      (rst),
    .clr      (idx_clr),
    .adv      (idx_adv),
    .chip_idx (chip_idx),
    .ch_idx   (ch_idx),
    .last     (idx_last)
  );

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      conv_cnt_q    <= 8'd0;
      to_cnt_q      <= 8'd0;
      convst_bar_q  <= 1'b1;
      rd_req_q      <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      rd_req_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (start && (state_q != ST_IDLE)) begin
        err_overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_CONV;
            conv_cnt_q   <= 8'd0;
            convst_bar_q <= 1'b0;
            frame_busy_q <= 1'b1;
          end
        end
        ST_CONV: begin
          if (conv_cnt_q == CONV_LAST) begin
            convst_bar_q <= 1'b1;
            to_cnt_q     <= 8'd0;
            state_q      <= ST_WAIT_BUSY;
          end else begin
            conv_cnt_q <= conv_cnt_q + 8'd1;
          end
        end
        ST_WAIT_BUSY: begin
          if (busy_clear) begin
            // First request launches on entry to REQ for minimum latency.
            rd_req_q <= 1'b1;
            state_q  <= ST_REQ;
          end else if (to_cnt_q == TO_LAST) begin
            err_timeout_q <= 1'b1;
            frame_busy_q  <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        ST_REQ: begin
          // Issue the request here only if it was not already launched on entry.
          rd_req_q <= ~rd_req_q;
          state_q  <= ST_WAIT_WORD;
        end
        ST_WAIT_WORD: begin
          if (word_done) begin
            if (idx_last) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          frame_busy_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign convst_bar  = convst_bar_q;
  assign rd_req      = rd_req_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule
